// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// Optional misaligned-redirect fault is enabled with FETCH_MISALIGN_EN.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   localparam int          IMM_IN_MSB  = 31;
   localparam int          IMM_IN_LSB  = 7;
   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] PC_INCR     = 32'(INSTR_BYTES);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with a synchronous flush.
// FIFO_DEPTH must be a power of two and at least 2.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int FIFO_DEPTH = 2,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int CW         = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  fetch_entry_t  push_data_i,
   input  logic          pop_i,
   output fetch_entry_t  head_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   fetch_entry_t  mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push_s;
   logic          do_pop_s;

   assign full_o    = (count_q == CW'(FIFO_DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign head_o    = mem_q[rd_ptr_q];
   assign do_push_s = push_i & ~full_o;
   assign do_pop_s  = pop_i & ~empty_o;

   // Storage, pointers and occupancy; flush wins over a same-cycle push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, requests words from instruction memory and buffers them for decode.
// Define FETCH_MISALIGN_EN to flag misaligned redirects on FetchFault and stall fetch until realigned.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ImemReqValid,
   input  logic        ImemReqReady,
   output logic [31:0] ImemAddr,
   input  logic        ImemRspValid,
   input  logic [31:0] ImemRspData,
   output logic        IdValid,
   input  logic        IdReady,
   output logic [31:0] IdInstr,
   output logic [31:0] IdPc,
   output logic [31:0] IdPcPlus4,
   output logic [24:0] IdImmIn,
   input  logic        Redirect,
   input  logic [31:0] RedirectPc,
   output logic        FetchFault
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam int          CW        = AW + 1;
   localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

   fetch_state_t  state_q;
   logic [31:0]   pc_q;
   logic [CW-1:0] out_q;
   logic [CW-1:0] out_d;
   logic [CW-1:0] drop_q;
   logic [31:0]   pcq_mem_q [FIFO_DEPTH];
   logic [AW-1:0] pcq_wr_q;
   logic [AW-1:0] pcq_rd_q;
   logic          fault_q;

   fetch_entry_t  head_s;
   fetch_entry_t  push_entry_s;
   logic [CW-1:0] fifo_count_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic          id_take_s;
   logic          req_valid_s;
   logic          req_fire_s;
   logic          push_s;
   logic          pop_s;
   logic [CW:0]   credit_used_s;
   logic [31:0]   redirect_pc_s;

   assign redirect_pc_s = align_word(RedirectPc);
   assign id_take_s     = ~fifo_empty_s & IdReady;

   // The head leaving this cycle frees its slot, so a streaming decode sees no bubbles.
   assign credit_used_s = {1'b0, out_q} + {1'b0, fifo_count_s} - {{CW{1'b0}}, id_take_s};
   assign req_valid_s   = (state_q == FETCH) && (credit_used_s < DEPTH_LIM) && !fault_q;
   assign req_fire_s    = req_valid_s & ImemReqReady;
   assign push_s        = (state_q == FETCH) & ImemRspValid & ~Redirect;
   assign pop_s         = id_take_s & ~Redirect;
   assign push_entry_s  = '{instr: ImemRspData, pc: pcq_mem_q[pcq_rd_q]};
   assign out_d         = out_q + CW'(req_fire_s) - CW'(ImemRspValid);

   fetch_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (Redirect),
      .push_i      (push_s),
      .push_data_i (push_entry_s),
      .pop_i       (pop_s),
      .head_o      (head_s),
      .count_o     (fifo_count_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s)
   );

   // Control FSM: PC advance, redirect handling and stale-response drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         drop_q  <= '0;
      end else begin
         case (state_q)
            BOOT: begin
               state_q <= FETCH;
               if (Redirect) begin
                  pc_q <= redirect_pc_s;
               end
            end
            FETCH: begin
               if (Redirect) begin
                  pc_q <= redirect_pc_s;
                  if (out_d != '0) begin
                     drop_q  <= out_d;
                     state_q <= FLUSH;
                  end
               end else if (req_fire_s) begin
                  pc_q <= pc_q + PC_INCR;
               end
            end
            FLUSH: begin
               if (Redirect) begin
                  pc_q <= redirect_pc_s;
               end
               if (drop_q == '0) begin
                  state_q <= FETCH;
               end else if (ImemRspValid) begin
                  drop_q <= drop_q - CW'(1);
               end
            end
            default: begin
               state_q <= BOOT;
               drop_q  <= '0;
            end
         endcase
      end
   end

   // Outstanding count and in-order PC queue; stale responses still retire their PC slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q    <= '0;
         pcq_wr_q <= '0;
         pcq_rd_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pcq_mem_q[i] <= '0;
         end
      end else begin
         out_q <= out_d;
         if (req_fire_s) begin
            pcq_mem_q[pcq_wr_q] <= pc_q;
            pcq_wr_q            <= pcq_wr_q + AW'(1);
         end
         if (ImemRspValid) begin
            pcq_rd_q <= pcq_rd_q + AW'(1);
         end
      end
   end

`ifdef FETCH_MISALIGN_EN
   // Sticky fault: set by a misaligned redirect, cleared only by an aligned one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else if (Redirect) begin
         fault_q <= (RedirectPc[1:0] != 2'b00);
      end
   end
`else
   logic redirect_lsb_unused_s;
   assign fault_q               = 1'b0;
   assign redirect_lsb_unused_s = ^RedirectPc[1:0];
`endif

   logic fifo_full_unused_s;
   assign fifo_full_unused_s = fifo_full_s;

   assign ImemReqValid = req_valid_s;
   assign ImemAddr     = pc_q;
   assign IdValid      = ~fifo_empty_s;
   assign IdInstr      = fifo_empty_s ? 32'h0000_0000 : head_s.instr;
   assign IdPc         = fifo_empty_s ? 32'h0000_0000 : head_s.pc;
   assign IdPcPlus4    = fifo_empty_s ? 32'h0000_0000 : head_s.pc + PC_INCR;
   assign IdImmIn      = fifo_empty_s ? 25'h000_0000 : head_s.instr[IMM_IN_MSB:IMM_IN_LSB];
   assign FetchFault   = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a stream-level model.
// Covers FETCH_MISALIGN_EN when the macro is defined for the build.
module tb_fetch_stage;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ImemReqValid;
   logic        ImemReqReady;
   logic [31:0] ImemAddr;
   logic        ImemRspValid;
   logic [31:0] ImemRspData;
   logic        IdValid;
   logic        IdReady;
   logic [31:0] IdInstr;
   logic [31:0] IdPc;
   logic [31:0] IdPcPlus4;
   logic [24:0] IdImmIn;
   logic        Redirect;
   logic [31:0] RedirectPc;
   logic        FetchFault;

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ImemReqValid (ImemReqValid),
      .ImemReqReady (ImemReqReady),
      .ImemAddr     (ImemAddr),
      .ImemRspValid (ImemRspValid),
      .ImemRspData  (ImemRspData),
      .IdValid      (IdValid),
      .IdReady      (IdReady),
      .IdInstr      (IdInstr),
      .IdPc         (IdPc),
      .IdPcPlus4    (IdPcPlus4),
      .IdImmIn      (IdImmIn),
      .Redirect     (Redirect),
      .RedirectPc   (RedirectPc),
      .FetchFault   (FetchFault)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: next address to be fetched, next PC to be delivered, expected fault flag.
   logic [31:0] exp_fetch;
   logic [31:0] exp_pc;
   logic        exp_fault;
   // Memory: in-order pending requests with the cycle each may respond.
   logic [31:0] pend_addr[$];
   int          pend_rdy[$];
   logic [31:0] deliv_pc[$];
   logic [24:0] deliv_imm[$];
   int          cyc;
   int          rr_pct  = 100;
   int          idr_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      if (a == 32'hFFFF_FFFC) return 32'hFFF0_0093;
      return a * 32'h0019_660D + 32'h3C6E_F35F;
   endfunction

   task automatic step(input bit redir, input logic [31:0] rpc);
      logic [31:0] ei;
      @(negedge clk);
      cyc++;
      ImemReqReady = ($urandom_range(99, 0) < rr_pct);
      IdReady      = ($urandom_range(99, 0) < idr_pct);
      Redirect     = redir;
      RedirectPc   = redir ? rpc : $urandom;
      if (pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
         ImemRspValid = 1'b1;
         ImemRspData  = instr_of(pend_addr.pop_front());
         void'(pend_rdy.pop_front());
      end else begin
         ImemRspValid = 1'b0;
         ImemRspData  = $urandom;
      end
      #1;
      check_eq("fetch_fault", FetchFault, exp_fault);
      if (exp_fault) check_eq("req_blocked", ImemReqValid, 1'b0);
      if (ImemReqValid && ImemReqReady) begin
         check_eq("imem_addr", ImemAddr, exp_fetch);
         pend_addr.push_back(ImemAddr);
         pend_rdy.push_back(cyc + $urandom_range(lat_max, lat_min));
         exp_fetch = exp_fetch + 32'd4;
         check_eq("credit", pend_addr.size() <= DEPTH, 1'b1);
      end
      if (IdValid && IdReady && !redir) begin
         ei = instr_of(exp_pc);
         check_eq("id_pc", IdPc, exp_pc);
         check_eq("id_instr", IdInstr, ei);
         check_eq("id_pc_plus4", IdPcPlus4, exp_pc + 32'd4);
         check_eq("id_imm_in", {7'd0, IdImmIn}, {7'd0, ei[31:7]});
         deliv_pc.push_back(IdPc);
         deliv_imm.push_back(IdImmIn);
         exp_pc = exp_pc + 32'd4;
      end
      if (redir) begin
         exp_fetch = {rpc[31:2], 2'b00};
         exp_pc    = {rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_EN
         exp_fault = (rpc[1:0] != 2'b00);
`endif
      end
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      ImemReqReady = 1'b0;
      ImemRspValid = 1'b0;
      ImemRspData  = 32'h0;
      IdReady      = 1'b0;
      Redirect     = 1'b0;
      RedirectPc   = 32'h0;
      pend_addr.delete();
      pend_rdy.delete();
      deliv_pc.delete();
      deliv_imm.delete();
      exp_fetch = 32'h0;
      exp_pc    = 32'h0;
      exp_fault = 1'b0;
      #1;
      check_eq("rst_req_valid", ImemReqValid, 1'b0);
      check_eq("rst_id_valid", IdValid, 1'b0);
      check_eq("rst_fault", FetchFault, 1'b0);
      check_eq("rst_instr", IdInstr, 32'h0);
      check_eq("rst_pc", IdPc, 32'h0);
      check_eq("rst_pc4", IdPcPlus4, 32'h0);
      check_eq("rst_imm", {7'd0, IdImmIn}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("boot_no_req", ImemReqValid, 1'b0);
      cyc = 0;
   endtask

   task automatic wait_deliv(input int n, input string tag);
      for (int k = 0; k < 60 && deliv_pc.size() < n; k++) step(1'b0, 32'h0);
      check_eq(tag, deliv_pc.size() >= n, 1'b1);
   endtask

   initial begin
      logic [31:0] t6_exp;
      logic [31:0] rpc;
      bit          redir;

      // Stream from reset: first request one cycle after BOOT, then no bubbles.
      do_reset();
      step(1'b0, 32'h0);
      check_eq("first_req_valid", ImemReqValid, 1'b1);
      check_eq("first_req_addr", ImemAddr, 32'h0);
      for (int i = 2; i <= 12; i++) begin
         step(1'b0, 32'h0);
         if (i >= 3) check_eq("no_bubble", IdValid, 1'b1);
      end

      // Reset mid-operation, then decode stalls for 10 cycles.
      do_reset();
      idr_pct = 0;
      repeat (10) step(1'b0, 32'h0);
      check_eq("stall_req_valid", ImemReqValid, 1'b0);
      check_eq("stall_id_valid", IdValid, 1'b1);
      check_eq("stall_head_pc", IdPc, 32'h0);
      check_eq("stall_outstanding", pend_addr.size(), 32'd0);
      idr_pct = 100;
      deliv_pc.delete();
      repeat (2) step(1'b0, 32'h0);
      check_eq("stall_deliv_n", deliv_pc.size(), 32'd2);
      if (deliv_pc.size() == 2) begin
         check_eq("stall_deliv0", deliv_pc[0], 32'h0);
         check_eq("stall_deliv1", deliv_pc[1], 32'h4);
      end

      // Redirect with two requests in flight.
      do_reset();
      lat_min = 3;
      lat_max = 3;
      repeat (2) step(1'b0, 32'h0);
      check_eq("t3_outstanding", pend_addr.size(), 32'd2);
      deliv_pc.delete();
      step(1'b1, 32'h0000_0100);
      step(1'b0, 32'h0);
      check_eq("t3_flush_noreq", ImemReqValid, 1'b0);
      wait_deliv(1, "t3_timeout");
      if (deliv_pc.size() >= 1) check_eq("t3_first_pc", deliv_pc[0], 32'h100);

      // Redirect coinciding with a pop and a response.
      lat_min = 1;
      lat_max = 1;
      repeat (8) step(1'b0, 32'h0);
      step(1'b1, 32'h0000_0200);
      check_eq("t4_cond", {IdValid, ImemRspValid, IdReady}, 3'b111);
      deliv_pc.delete();
      step(1'b0, 32'h0);
      check_eq("t4_flushed", IdValid, 1'b0);
      wait_deliv(1, "t4_timeout");
      if (deliv_pc.size() >= 1) check_eq("t4_first_pc", deliv_pc[0], 32'h200);

      // PC wrap and immediate slice.
      deliv_pc.delete();
      deliv_imm.delete();
      step(1'b1, 32'hFFFF_FFFC);
      wait_deliv(2, "t5_timeout");
      if (deliv_pc.size() >= 2) begin
         check_eq("t5_pc0", deliv_pc[0], 32'hFFFF_FFFC);
         check_eq("t5_imm", {7'd0, deliv_imm[0]}, 32'h01FF_E001);
         check_eq("t5_pc1", deliv_pc[1], 32'h0);
      end

      // Misaligned redirect.
      deliv_pc.delete();
      step(1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_EN
      repeat (8) step(1'b0, 32'h0);
      check_eq("t6_fault", FetchFault, 1'b1);
      check_eq("t6_no_deliv", deliv_pc.size(), 32'd0);
      step(1'b1, 32'h0000_0200);
      deliv_pc.delete();
      t6_exp = 32'h200;
`else
      t6_exp = 32'h100;
`endif
      wait_deliv(1, "t6_timeout");
      if (deliv_pc.size() >= 1) check_eq("t6_resume", deliv_pc[0], t6_exp);
      check_eq("t6_fault_clear", FetchFault, 1'b0);

      // Randomized traffic.
      rr_pct  = 75;
      idr_pct = 70;
      lat_min = 1;
      lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         redir = ($urandom_range(99, 0) < 3);
         rpc   = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         step(redir, rpc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the RV32I pipeline, directly upstream of decode.
- Owns the PC and issues word requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Supplies decode with the raw instruction, its PC, PC+4 and the Instr[31:7] slice consumed by the immediate-extension unit; handles branch/jump redirects, including discarding in-flight stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2); also the maximum outstanding plus buffered instructions.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ImemReqValid  out  1  fetch request valid.
- ImemReqReady  in  1  memory accepts request.
- ImemAddr  out  32  word-aligned fetch address.
- ImemRspValid  in  1  response data valid.
- ImemRspData  in  32  instruction word.
- IdValid  out  1  FIFO head valid toward decode.
- IdReady  in  1  decode consumes head.
- IdInstr  out  32  head instruction.
- IdPc  out  32  head instruction PC.
- IdPcPlus4  out  32  IdPc + 4.
- IdImmIn  out  25  IdInstr[31:7], feeds the immediate unit.
- Redirect  in  1  taken branch/jump/trap redirect.
- RedirectPc  in  32  redirect target.
- FetchFault  out  1  misaligned redirect flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async, rst_n=0) values:
  - PC = RESET_PC; state = BOOT; FIFO empty; outstanding = 0; drop_cnt = 0.
  - ImemReqValid = 0, IdValid = 0, FetchFault = 0.
  - IdInstr, IdPc, IdPcPlus4 and IdImmIn read 0 while the FIFO is empty.
- Memory protocol:
  - Responses return in order, exactly one per accepted request, no earlier than the cycle after acceptance.
  - ImemRspValid has no back-pressure.
- States:
  - BOOT: one cycle, no requests, then goes to FETCH.
  - FETCH:
    - ImemReqValid = 1 when outstanding + fifo_count < FIFO_DEPTH.
    - ImemAddr = PC.
    - On ReqValid & ReqReady: PC += 4 and outstanding += 1.
  - FLUSH:
    - ImemReqValid = 0.
    - Each ImemRspValid is discarded and decrements drop_cnt and outstanding.
    - Goes to FETCH in the cycle after drop_cnt reaches 0.
- Response path:
  - In FETCH, ImemRspValid writes {ImemRspData, pc_of_request} into the FIFO and decrements outstanding.
  - pc_of_request is held in a FIFO_DEPTH-entry in-order PC queue.
- Credit rule: the FIFO can never overflow. An overflow attempt is a bug; the bench asserts against it.
- Decode handshake:
  - Head is popped on IdValid & IdReady.
  - IdValid is 1 iff the FIFO is non-empty; it is registered and has no combinational path from IdReady.
  - Push and pop in the same cycle is allowed; count is unchanged.
- Redirect (priority over every other event in the same cycle):
  - PC <= RedirectPc and the FIFO is cleared; a same-cycle pop is ignored.
  - Any request handshaking in that cycle is counted as stale.
  - Define n = outstanding after this cycle's response and request.
  - If n > 0: drop_cnt <= n and go to FLUSH. Otherwise stay in FETCH.
  - Redirect during FLUSH: PC is updated and drop_cnt is unchanged.
  - Redirect during BOOT: PC is updated and BOOT completes normally.
- Arithmetic:
  - All PC arithmetic is mod 2^32. PC 32'hFFFF_FFFC + 4 wraps to 0.
  - RedirectPc[1:0] is forced to 00.
- Reset asserted mid-operation: all state returns to reset values immediately; no request is held.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Defined:
  - A redirect with RedirectPc[1:0] != 0 sets FetchFault sticky, flushes as normal, and blocks new requests.
  - An aligned redirect clears FetchFault and resumes fetch.
- Undefined:
  - FetchFault is tied 0.
  - The low two bits of RedirectPc are ignored.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {BOOT, FETCH, FLUSH}.
  - Constants IMM_IN_MSB = 31, IMM_IN_LSB = 7, INSTR_BYTES = 4.
  - Struct fetch_entry_t {instr[31:0], pc[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with synchronous flush, count, full and empty; parameterised by FIFO_DEPTH.

Test Plan:
- Reset release, ImemReqReady = 1, 1-cycle memory latency, IdReady = 1 -> first request in cycle 2 with ImemAddr = 0x0. IdPc sequence 0x0, 0x4, 0x8, ... with no bubbles after fill.
- IdReady = 0 for 10 cycles -> exactly 2 instructions buffered and ImemReqValid = 0. On release, PCs 0x0 and 0x4 are delivered in order.
- Redirect to 0x100 with 2 requests outstanding -> FLUSH, 2 responses discarded, next delivered IdPc = 0x100 and IdPcPlus4 = 0x104.
- Redirect in the same cycle as IdValid & IdReady and an ImemRspValid -> FIFO empty next cycle, no stale instruction reaches decode.
- RedirectPc = 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0. IdImmIn equals IdInstr[31:7] for instr 0xFFF0_0093 (0x1FFE001).
- FETCH_MISALIGN_EN defined, RedirectPc = 0x102 -> FetchFault = 1 and no requests. Redirect to 0x200 -> FetchFault = 0 and fetch resumes at 0x200.
